// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, the halt encoding,
// the IF/ID bundle and the next-PC source selector.
package mips_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [31:0] HALT_WORD = 32'h0000_000C;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } ifid_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_JUMP
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction-memory port plus the IF/ID handshake to decode.
interface fetch_stage_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_rd_i;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] pc_o;
  logic [AW-1:0] pc_plus1_o;
  logic          valid_o;
  logic          ready_i;
  logic          branch_i;
  logic [AW-1:0] branch_off_i;
  logic          jump_i;
  logic [AW-1:0] jump_addr_i;
  logic          halt_o;

  modport master (
    output imem_addr_o, instr_o, pc_o, pc_plus1_o, valid_o, halt_o,
    input  imem_rd_i, ready_i, branch_i, branch_off_i, jump_i, jump_addr_i
  );

  modport slave (
    input  imem_addr_o, instr_o, pc_o, pc_plus1_o, valid_o, halt_o,
    output imem_rd_i, ready_i, branch_i, branch_off_i, jump_i, jump_addr_i
  );
endinterface

// File: rtl/fetch_stage_pc_next.sv
// Combinational next-PC mux: hold, sequential, PC-relative branch or absolute jump.
module pc_next
  import mips_pkg::*;
#(
  parameter int unsigned AW = mips_pkg::AW
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] ifid_pc,
  input  logic [AW-1:0] branch_off,
  input  logic [AW-1:0] jump_addr,
  input  pc_sel_e       sel,
  output logic [AW-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (sel)
      PC_HOLD:   next_pc = pc;
      PC_INC:    next_pc = pc + AW'(1);
      // Offset is as wide as the PC, so modular addition already sign-extends it.
      PC_BRANCH: next_pc = ifid_pc + AW'(1) + branch_off;
      PC_JUMP:   next_pc = jump_addr;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register with valid/ready handoff,
// branch/jump redirect and sticky halt on the syscall word.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned   AW        = mips_pkg::AW,
  parameter int unsigned   DW        = mips_pkg::DW,
  parameter logic [DW-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic          stall_i,
  fetch_stage_if.master bus
);

  logic [AW-1:0] pc;
  logic [AW-1:0] next_pc;
  ifid_t         ifid;
  logic          valid;
  logic          halt;
  logic          adv;
  logic          redir;
  logic          is_halt;
  pc_sel_e       sel;

  assign adv     = run_i & ~halt & ~stall_i & (~valid | bus.ready_i);
  assign redir   = valid & bus.ready_i & (bus.jump_i | bus.branch_i) & ~halt;
  assign is_halt = (bus.imem_rd_i == HALT_WORD);

  always_comb begin
    sel = PC_HOLD;
    if (redir)              sel = bus.jump_i ? PC_JUMP : PC_BRANCH;
    else if (adv & ~is_halt) sel = PC_INC;
  end

  pc_next #(.AW(AW)) u_pc_next (
    .pc         (pc),
    .ifid_pc    (ifid.pc),
    .branch_off (bus.branch_off_i),
    .jump_addr  (bus.jump_addr_i),
    .sel        (sel),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      ifid  <= '0;
      valid <= 1'b0;
      halt  <= 1'b0;
    end else begin
      pc <= next_pc;
      if (redir) begin
        valid <= 1'b0;
      end else if (adv && is_halt) begin
        // The halt word is swallowed; only the word being handed off drains.
        halt <= 1'b1;
        if (bus.ready_i) valid <= 1'b0;
      end else if (adv) begin
        ifid  <= '{instr: bus.imem_rd_i, pc: pc};
        valid <= 1'b1;
      end else if (valid && bus.ready_i) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.imem_addr_o = pc;
  assign bus.instr_o     = ifid.instr;
  assign bus.pc_o        = ifid.pc;
  assign bus.pc_plus1_o  = ifid.pc + AW'(1);
  assign bus.valid_o     = valid;
  assign bus.halt_o      = halt;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a program-order model predicts each accepted
// {pc, instr}; a monitor compares whenever decode takes an instruction.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'h0000_000C;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic stall = 1'b0;

  logic [31:0] mem [256];
  exp_t        sbq [$];
  exp_t        mon_e;
  logic [7:0]  m_cur;
  logic        m_halt;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if #(.AW(8), .DW(32)) bus ();

  fetch_stage #(.AW(8), .DW(32), .HALT_WORD(32'h0000_000C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (run),
    .stall_i (stall),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rd_i = mem[bus.imem_addr_o];

  function automatic logic [7:0] inc8(input logic [7:0] a);
    logic [7:0] r;
    r = a + 8'd1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: instruction n+1 follows from instruction n and the
  // redirect decode gave when it took instruction n.
  task automatic model_push(input logic [7:0] a);
    exp_t e;
    m_cur = a;
    if (mem[a] == HALT) begin
      m_halt = 1'b1;
    end else begin
      e.pc    = a;
      e.instr = mem[a];
      sbq.push_back(e);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic rd, input logic b,
                      input logic [7:0] off, input logic j, input logic [7:0] ja);
    logic [7:0] nxt;
    run              = r;
    stall            = s;
    bus.ready_i      = rd;
    bus.branch_i     = b;
    bus.branch_off_i = off;
    bus.jump_i       = j;
    bus.jump_addr_i  = ja;
    if (bus.valid_o && rd && !m_halt) begin
      if (j)      nxt = ja;
      else if (b) nxt = m_cur + 8'd1 + off;
      else        nxt = m_cur + 8'd1;
      model_push(nxt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_halt", 32'(bus.halt_o), 32'd0);
    chk("rst_pc", 32'(bus.pc_o), 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr_o), 32'd0);
    sbq.delete();
    m_halt = 1'b0;
    model_push(8'd0);
    run = 1'b1; stall = 1'b0; bus.ready_i = 1'b0;
    bus.branch_i = 1'b0; bus.jump_i = 1'b0;
    bus.branch_off_i = '0; bus.jump_addr_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept actual_pc=%h expected=none", bus.pc_o);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_pc", 32'(bus.pc_o), 32'(mon_e.pc));
        chk("sb_instr", bus.instr_o, mon_e.instr);
        chk("sb_pc_plus1", 32'(bus.pc_plus1_o), 32'(inc8(mon_e.pc)));
      end
    end
  end

  initial begin
    logic [31:0] w;
    bit done;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT) w = w ^ 32'h1;
      mem[i] = w;
    end
    m_cur = '0;
    m_halt = 1'b0;

    apply_reset();
    chk("first_valid", 32'(bus.valid_o), 32'd1);
    chk("first_pc", 32'(bus.pc_o), 32'd0);
    chk("first_imem_addr", 32'(bus.imem_addr_o), 32'd1);

    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 1, 0, 8'h00, 0, 8'h00);
      chk("stream_valid", 32'(bus.valid_o), 32'd1);
      chk("stream_pc", 32'(bus.pc_o), 32'(m_cur));
      chk("stream_imem_addr", 32'(bus.imem_addr_o), 32'(inc8(m_cur)));
    end

    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 8'h00, 0, 8'h00);
      chk("bp_valid", 32'(bus.valid_o), 32'd1);
      chk("bp_pc", 32'(bus.pc_o), 32'(m_cur));
      chk("bp_imem_addr", 32'(bus.imem_addr_o), 32'(inc8(m_cur)));
    end
    tick(1, 0, 1, 0, 8'h00, 0, 8'h00);
    chk("bp_release_pc", 32'(bus.pc_o), 32'(m_cur));

    tick(1, 0, 1, 1, 8'hFE, 0, 8'h00);
    chk("br_bubble", 32'(bus.valid_o), 32'd0);
    chk("br_imem_addr", 32'(bus.imem_addr_o), 32'(m_cur));
    tick(1, 0, 1, 0, 8'h00, 0, 8'h00);
    chk("br_valid", 32'(bus.valid_o), 32'd1);
    chk("br_pc", 32'(bus.pc_o), 32'(m_cur));

    tick(1, 0, 1, 1, 8'h05, 1, 8'h40);
    chk("jmp_imem_addr", 32'(bus.imem_addr_o), 32'h40);
    chk("jmp_bubble", 32'(bus.valid_o), 32'd0);
    tick(1, 0, 1, 0, 8'h00, 0, 8'h00);
    chk("jmp_pc", 32'(bus.pc_o), 32'h40);

    tick(1, 0, 1, 0, 8'h00, 1, 8'hFF);
    chk("wrap_imem_ff", 32'(bus.imem_addr_o), 32'hFF);
    tick(1, 0, 1, 0, 8'h00, 0, 8'h00);
    chk("wrap_pc", 32'(bus.pc_o), 32'hFF);
    chk("wrap_imem_00", 32'(bus.imem_addr_o), 32'h00);
    chk("wrap_pc_plus1", 32'(bus.pc_plus1_o), 32'h00);

    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
           8'($urandom), $urandom_range(0, 9) == 0, 8'($urandom));
    end

    #2;
    apply_reset();
    chk("restart_pc", 32'(bus.pc_o), 32'd0);
    chk("restart_valid", 32'(bus.valid_o), 32'd1);

    mem[5] = HALT;
    #2;
    apply_reset();
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(1, 0, 1, 0, 8'h00, 0, 8'h00);
      if (bus.halt_o) done = 1'b1;
    end
    chk("halt_reached", 32'(done), 32'd1);
    chk("halt_valid", 32'(bus.valid_o), 32'd0);
    chk("halt_imem_addr", 32'(bus.imem_addr_o), 32'd5);
    chk("halt_last_pc", 32'(bus.pc_o), 32'd4);
    chk("halt_sb_empty", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1, 1, 8'h10, 1, 8'h80);
      chk("halt_sticky", 32'(bus.halt_o), 32'd1);
      chk("halt_no_redir", 32'(bus.imem_addr_o), 32'd5);
      chk("halt_no_valid", 32'(bus.valid_o), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
